seq_mult_8: RTL and testbench
=============================

# seq_mult_8

Sequential 8x8 unsigned shift-add multiplier that drives the team's 8-bit Kogge-Stone adder (`ksa_8`) as its partial-product adder. Each cycle it feeds the adder one operand pair and consumes the adder's SUM/CARRY. It produces a 16-bit product after 8 iterations and uses a START/READY/DONE handshake. The block sits directly upstream of `ksa_8` in the arithmetic datapath and is the first sequential user of it.

## Interface
- WIDTH, 8, operand width; only 8 is legal because `ksa_8` is fixed-width. Any other value must be rejected at elaboration.
- Clocking: one clock; reset is asynchronous and active-high.
- CLK  in  1  system clock, rising-edge.
- RST  in  1  asynchronous, active-high reset.
- START  in  1  request a multiply; sampled only when READY=1.
- A  in  8  multiplicand; sampled with START.
- B  in  8  multiplier; sampled with START.
- READY  out  1  block idle, will accept START.
- BUSY  out  1  multiply in progress (RUN state).
- DONE  out  1  one-cycle pulse; PRODUCT valid.
- PRODUCT  out  16  unsigned A*B; held until the next accepted START completes.

## Operation
- States:
  - IDLE: READY=1.
  - RUN: BUSY=1; 3-bit iteration counter CNT.
  - DONE: DONE=1.
- IDLE -> RUN: on a rising edge with START=1.
  - Latch MCAND<=A.
  - Latch the product register P[16:0] <= {9'b0, B}. P[16] is the carry slot, P[15:8] is ACC, P[7:0] is the remaining multiplier bits.
  - Set CNT<=0.
- Each RUN edge:
  - The adder inputs are A_in=P[15:8], B_in=(P[0] ? MCAND : 8'h00), CIN=0.
  - Update P <= {1'b0, CARRY, SUM, P[7:1]}, a logical right shift by one.
  - Increment CNT.
- RUN -> DONE: on the edge where CNT==7, i.e. the 8th iteration. At that edge PRODUCT<=P[15:0]; P[16] is always 0 at that point.
- DONE -> IDLE: unconditionally on the next edge.
- START in RUN or DONE is ignored and not queued.
- A and B may change freely after acceptance; the latched copies are used.
- Arithmetic:
  - The result is unsigned and exact, with no overflow (16 bits).
  - The adder CARRY is never dropped; it enters P[16] before the shift.

## Timing
- Reset values:
  - State=IDLE, READY=1, BUSY=0, DONE=0, PRODUCT=16'h0000, P=0, MCAND=0, CNT=0.
- Edge numbering:
  - Edge 0 accepts START.
  - Edges 1..8 perform iterations 0..7.
  - DONE is high in the cycle after edge 8. Latency is 8 cycles from the accepting edge to DONE visible.
  - Edge 9 returns to IDLE.
- Throughput: with START held high, a new operation is accepted every 10 edges (edges 0, 10, 20, ...).
- READY is low from edge 0 until edge 9.
- READY and BUSY are decoded from state only; they have no combinational path from START.
- PRODUCT changes only at the RUN->DONE edge or on reset. It is stable during RUN of the next operation.
- Reset asserted mid-RUN or mid-DONE:
  - Aborts immediately and asynchronously.
  - No DONE pulse is issued; PRODUCT is cleared.
  - After release, the first rising edge with START=1 starts a fresh operation.
- Zero multiplier: still takes the full 8 iterations; there is no early termination.

## Structure
- Shared package `mult_pkg`:
  - State encoding localparams: IDLE=2'd0, RUN=2'd1, DONE=2'd2. Encoding 2'd3 is illegal and recovers to IDLE.
  - WIDTH=8, ITER=8, CNT_W=3.
- One sub-module: `ksa_8`, instantiated once, purely combinational, positional ports (A, B, CIN, SUM, CARRY).
- All other logic stays in `seq_mult_8`: the FSM, the counter, and the P, MCAND and PRODUCT registers.

## Test plan
- Reset then idle check: assert RST mid-sim.
  - During reset: READY=1, BUSY=0, DONE=0, PRODUCT=0000.
  - After release, no DONE appears without START.
- Basic products, each START a single cycle, wait for DONE:
  - A=00, B=01 -> PRODUCT=0000.
  - A=77, B=55 -> 2783.
  - A=0C, B=14 -> 00F0.
- Carry-heavy products, checking that CARRY is propagated:
  - A=EA, B=D5 -> C2B2.
  - A=85, B=FF -> 847B.
  - A=FF, B=FF -> FE01.
- Latency and handshake:
  - Check that DONE rises exactly 8 cycles after the accepting edge and stays high exactly 1 cycle.
  - Toggle A/B and pulse START during RUN: the result is unchanged, with no extra operation.
- Back-to-back: hold START=1 with A=FF, B=02 then A=03, B=03.
  - DONE pulses 10 cycles apart.
  - PRODUCT reads 01FE, then 0009.
- Reset mid-operation: assert RST at iteration 4 of A=77, B=55.
  - PRODUCT=0000, no DONE.
  - A fresh START of A=0C, B=14 then yields 00F0.

Source files
------------

// File: rtl/mult_pkg.sv
// Shared constants and state encoding for the sequential shift-add multiplier.
// The encoding is fixed so that the unused code 2'd3 has a known recovery path.
package mult_pkg;

    localparam int WIDTH = 8;
    localparam int ITER  = 8;
    localparam int CNT_W = 3;

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(ITER - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/ksa_8.sv
// 8-bit Kogge-Stone adder, purely combinational.
// Carry-in is folded into bit 0's generate so the prefix tree yields every carry directly.
module ksa_8 (
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       cin,
    output logic [7:0] sum,
    output logic       carry
);

    logic [7:0] g0, p0;
    logic [7:0] g1, p1;
    logic [7:0] g2, p2;
    logic [7:0] g3, p3;
    logic [7:0] prop;
    logic [7:0] carries;

    always_comb begin
        prop = a ^ b;
        g0   = a & b;
        g0[0] = (a[0] & b[0]) | (prop[0] & cin);
        p0   = prop;

        g1 = g0;
        p1 = p0;
        for (int i = 1; i < 8; i++) begin
            g1[i] = g0[i] | (p0[i] & g0[i-1]);
            p1[i] = p0[i] & p0[i-1];
        end

        g2 = g1;
        p2 = p1;
        for (int i = 2; i < 8; i++) begin
            g2[i] = g1[i] | (p1[i] & g1[i-2]);
            p2[i] = p1[i] & p1[i-2];
        end

        g3 = g2;
        p3 = p2;
        for (int i = 4; i < 8; i++) begin
            g3[i] = g2[i] | (p2[i] & g2[i-4]);
            p3[i] = p2[i] & p2[i-4];
        end

        // g3[i] is the carry out of bit i, hence the carry into bit i+1
        carries = {g3[6:0], cin};
        sum     = prop ^ carries;
        carry   = g3[7];
    end

endmodule

// File: rtl/seq_mult_8.sv
// Sequential 8x8 unsigned shift-add multiplier: one ksa_8 addition per cycle,
// eight iterations per product, START/READY/DONE handshake.
module seq_mult_8
    import mult_pkg::*;
#(
    parameter int WIDTH = mult_pkg::WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 ready,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    // ksa_8 is fixed-width, so any other operand width cannot be built
    generate
        if (WIDTH != 8) begin : g_bad_width
            $error("seq_mult_8: WIDTH must be 8");
        end
    endgenerate

    state_t             state, next_state;
    logic [16:0]        p;
    logic [7:0]         mcand;
    logic [CNT_W-1:0]   cnt;

    logic [7:0]         add_b;
    logic [7:0]         add_sum;
    logic               add_carry;
    logic [16:0]        p_shifted;
    logic               unused_carry_slot;

    assign add_b     = p[0] ? mcand : 8'h00;
    assign p_shifted = {1'b0, add_carry, add_sum, p[7:1]};

    // The carry slot is cleared by every shift and never feeds the datapath
    assign unused_carry_slot = p[16];

    ksa_8 u_ksa (p[15:8], add_b, 1'b0, add_sum, add_carry);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = IDLE;
        ready      = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                ready      = 1'b1;
                next_state = start ? RUN : IDLE;
            end
            RUN: begin
                busy       = 1'b1;
                next_state = (cnt == LAST_CNT) ? DONE : RUN;
            end
            DONE: begin
                done       = 1'b1;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // PRODUCT captures the post-shift value of the final iteration
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            p       <= '0;
            mcand   <= '0;
            cnt     <= '0;
            product <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        mcand <= a;
                        p     <= {9'b0, b};
                        cnt   <= '0;
                    end
                end
                RUN: begin
                    p   <= p_shifted;
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST_CNT) begin
                        product <= p_shifted[15:0];
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_mult_8.sv
// Self-checking bench for seq_mult_8: directed vector table, handshake and reset
// sequences, and randomized operands compared against plain a*b arithmetic.
module tb_seq_mult_8;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [7:0]  a, b;
    logic        ready, busy, done;
    logic [15:0] product;

    int checks = 0;
    int errors = 0;
    logic [15:0] model_product = 16'h0000;

    typedef struct {
        logic [7:0]  a;
        logic [7:0]  b;
        logic [15:0] expected;
    } vec_t;

    vec_t vectors[6];

    seq_mult_8 dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .a       (a),
        .b       (b),
        .ready   (ready),
        .busy    (busy),
        .done    (done),
        .product (product)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] required);
        checks++;
        if (actual !== required) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, required);
        end
    endtask

    // Run one multiply; optionally scramble inputs and pulse START while it runs
    task automatic apply_stimulus(input logic [7:0] va, input logic [7:0] vb, input bit disturb);
        logic [15:0] expected;
        int          latency;
        bit          seen;
        expected = 16'(int'(va) * int'(vb));
        check_output("ready_before_start", ready, 1);
        a = va;
        b = vb;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check_output("busy_after_accept", busy, 1);
        check_output("ready_after_accept", ready, 0);
        seen = 0;
        latency = 0;
        for (int n = 1; n <= 14 && !seen; n++) begin
            if (disturb) begin
                a = 8'($urandom);
                b = 8'($urandom);
                start = 1'($urandom_range(0, 1));
            end
            @(posedge clk); #1;
            if (done) begin
                seen = 1;
                latency = n;
            end else begin
                check_output("product_stable_in_run", product, model_product);
            end
        end
        start = 1'b0;
        check_output("done_seen", seen, 1);
        check_output("done_latency", latency, 8);
        check_output("product", product, expected);
        model_product = expected;
        @(posedge clk); #1;
        check_output("done_one_cycle", done, 0);
        check_output("ready_after_done", ready, 1);
        check_output("product_held", product, model_product);
    endtask

    initial begin
        int d1, d2;

        vectors[0] = '{8'h00, 8'h01, 16'h0000};
        vectors[1] = '{8'h77, 8'h55, 16'h2783};
        vectors[2] = '{8'h0C, 8'h14, 16'h00F0};
        vectors[3] = '{8'hEA, 8'hD5, 16'hC2B2};
        vectors[4] = '{8'h85, 8'hFF, 16'h847B};
        vectors[5] = '{8'hFF, 8'hFF, 16'hFE01};

        rst = 1'b1;
        start = 1'b0;
        a = 8'h00;
        b = 8'h00;
        #12;
        check_output("reset_ready", ready, 1);
        check_output("reset_busy", busy, 0);
        check_output("reset_done", done, 0);
        check_output("reset_product", product, 16'h0000);
        @(negedge clk);
        rst = 1'b0;
        for (int n = 0; n < 12; n++) begin
            @(posedge clk); #1;
            check_output("idle_no_done", done, 0);
        end

        for (int i = 0; i < 6; i++) begin
            apply_stimulus(vectors[i].a, vectors[i].b, 0);
            check_output("vector_product", product, vectors[i].expected);
        end

        // Inputs and stray START pulses during RUN must not disturb the result
        apply_stimulus(8'h77, 8'h55, 1);
        apply_stimulus(8'hEA, 8'hD5, 1);

        // Back-to-back with START held high
        a = 8'hFF;
        b = 8'h02;
        start = 1'b1;
        @(posedge clk); #1;
        a = 8'h03;
        b = 8'h03;
        d1 = -1;
        d2 = -1;
        for (int n = 1; n <= 30 && d2 < 0; n++) begin
            if (n == 11) start = 1'b0;
            @(posedge clk); #1;
            if (done) begin
                if (d1 < 0) begin
                    d1 = n;
                    check_output("b2b_first_product", product, 16'h01FE);
                end else begin
                    d2 = n;
                    check_output("b2b_second_product", product, 16'h0009);
                end
            end
        end
        start = 1'b0;
        check_output("b2b_first_latency", d1, 8);
        check_output("b2b_spacing", d2 - d1, 10);
        model_product = 16'h0009;
        @(posedge clk); #1;

        // Abort in the middle of an operation
        a = 8'h77;
        b = 8'h55;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check_output("abort_product", product, 16'h0000);
        check_output("abort_done", done, 0);
        check_output("abort_ready", ready, 1);
        check_output("abort_busy", busy, 0);
        model_product = 16'h0000;
        @(negedge clk);
        rst = 1'b0;
        for (int n = 0; n < 12; n++) begin
            @(posedge clk); #1;
            check_output("abort_no_done", done, 0);
        end
        apply_stimulus(8'h0C, 8'h14, 0);

        for (int i = 0; i < 16; i++) begin
            apply_stimulus(8'($urandom), 8'($urandom), bit'(i % 2));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
